// File: rtl/c3aibadapt_tx_dprio_avmm_pkg.sv
// Shared definitions for the TX adapter DPRIO Avalon-MM register block.
package c3aibadapt_tx_dprio_avmm_pkg;

  // Bus handshake FSM: IDLE stalls, ACK accepts the request.
  typedef enum logic [0:0] {
    StIdle,
    StAck
  } avmm_state_e;

  // Register byte addresses.
  localparam logic [5:0] AddrCtrl        = 6'h00;
  localparam logic [5:0] AddrFullEmpty   = 6'h01;
  localparam logic [5:0] AddrPfullPempty = 6'h02;
  localparam logic [5:0] AddrGearbox     = 6'h03;
  localparam logic [5:0] AddrCompCnt     = 6'h04;
  localparam logic [5:0] AddrMisc        = 6'h05;
  localparam logic [5:0] AddrClkLo       = 6'h06;
  localparam logic [5:0] AddrClkHi       = 6'h07;
  localparam logic [5:0] AddrErrCnt      = 6'h08;

  // 0x00 fields.
  localparam int unsigned TenGModeBit   = 0;
  localparam int unsigned IndvBit       = 1;
  localparam int unsigned FifoModeLsb   = 2;
  localparam int unsigned DoubleReadBit = 5;
  localparam int unsigned StopReadBit   = 6;
  localparam int unsigned StopWriteBit  = 7;

  // 0x01 / 0x02 fields.
  localparam int unsigned FullLsb   = 0;
  localparam int unsigned EmptyLsb  = 4;
  localparam int unsigned PfullLsb  = 0;
  localparam int unsigned PemptyLsb = 4;

  // 0x03 fields.
  localparam int unsigned GbIdwidthLsb = 0;
  localparam int unsigned GbOdwidthLsb = 3;
  localparam int unsigned PhcompLsb    = 5;

  // 0x05 fields.
  localparam int unsigned FullTypeBit   = 0;
  localparam int unsigned EmptyTypeBit  = 1;
  localparam int unsigned PfullTypeBit  = 2;
  localparam int unsigned PemptyTypeBit = 3;
  localparam int unsigned CompinSelLsb  = 4;
  localparam int unsigned UsMasterBit   = 6;
  localparam int unsigned DsMasterBit   = 7;

  // 0x07 fields.
  localparam int unsigned ClkHiLsb = 0;
  localparam int unsigned LockBit  = 7;

  // Addresses 0x00-0x06 are the lockable configuration bytes.
  function automatic logic is_lockable_addr(logic [5:0] addr);
    return addr < AddrClkHi;
  endfunction

endpackage

// File: rtl/c3aibadapt_cfg_errcnt.sv
// Saturating 8-bit error counter with a sticky error flag; both clear only on reset.
module c3aibadapt_cfg_errcnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  output logic [7:0] cnt_o,
  output logic       err_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Next-state: count up to 0xFF and hold there.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i) begin
      err_d = 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/c3aibadapt_tx_dprio_avmm.sv
// Avalon-MM configuration register block for the TX adapter. Every access takes two
// cycles (IDLE stall, ACK accept); writes commit and reads register at the end of ACK.
module c3aibadapt_tx_dprio_avmm
  import c3aibadapt_tx_dprio_avmm_pkg::*;
(
  input  logic       avmm_clk,
  input  logic       avmm_rst_n,
  input  logic [5:0] avmm_address,
  input  logic       avmm_write,
  input  logic       avmm_read,
  input  logic [7:0] avmm_writedata,
  output logic [7:0] avmm_readdata,
  output logic       avmm_readdatavalid,
  output logic       avmm_waitrequest,
  output logic       r_10g_mode,
  output logic       r_indv,
  output logic [2:0] r_fifo_mode,
  output logic       r_double_read,
  output logic       r_stop_read,
  output logic       r_stop_write,
  output logic [3:0] r_full,
  output logic [3:0] r_empty,
  output logic [3:0] r_pfull,
  output logic [3:0] r_pempty,
  output logic [2:0] r_gb_idwidth,
  output logic [1:0] r_gb_odwidth,
  output logic [2:0] r_phcomp_rd_delay,
  output logic [7:0] r_comp_cnt,
  output logic       r_full_type,
  output logic       r_empty_type,
  output logic       r_pfull_type,
  output logic       r_pempty_type,
  output logic [1:0] r_compin_sel,
  output logic       r_us_master,
  output logic       r_ds_master,
  output logic [9:0] tx_user_clk_config,
  output logic       cfg_err
);

  avmm_state_e state_q, state_d;
  logic        rd_pend_q, wr_pend_q;
  logic [7:0]  ctrl_q, ctrl_d, fe_q, fe_d, pfe_q, pfe_d, gb_q, gb_d;
  logic [7:0]  comp_q, comp_d, misc_q, misc_d, clk_lo_q, clk_lo_d;
  logic [1:0]  clk_hi_q, clk_hi_d;
  logic        lock_q, lock_d;
  logic [7:0]  readdata_q, readdata_d;
  logic        rvalid_q;
  logic [7:0]  err_cnt;
  logic        err_flag;

  logic       req_wr, req_rd, do_wr, do_rd, wr_commit, err_inc;
  logic [7:0] rd_mux;

  // Handshake FSM next-state; every ACK returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (avmm_read || avmm_write) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and the request kind seen in IDLE, so a request dropped before ACK completes.
  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      state_q   <= StIdle;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        rd_pend_q <= avmm_read;
        wr_pend_q <= avmm_write;
      end
    end
  end

  // Access decode in ACK: write wins over a simultaneous read, which is flagged as an error.
  always_comb begin
    req_wr    = avmm_write || wr_pend_q;
    req_rd    = avmm_read || rd_pend_q;
    do_wr     = (state_q == StAck) && req_wr;
    do_rd     = (state_q == StAck) && req_rd && !req_wr;
    // 0x07 stays writable under lock so the lock can be released.
    wr_commit = do_wr && ((avmm_address == AddrClkHi) ||
                          (is_lockable_addr(avmm_address) && !lock_q));
    err_inc   = (do_wr && !wr_commit) || (do_wr && req_rd);
  end

  // Register write decode.
  always_comb begin
    ctrl_d   = ctrl_q;
    fe_d     = fe_q;
    pfe_d    = pfe_q;
    gb_d     = gb_q;
    comp_d   = comp_q;
    misc_d   = misc_q;
    clk_lo_d = clk_lo_q;
    clk_hi_d = clk_hi_q;
    lock_d   = lock_q;
    if (wr_commit) begin
      case (avmm_address)
        AddrCtrl:        ctrl_d   = avmm_writedata;
        AddrFullEmpty:   fe_d     = avmm_writedata;
        AddrPfullPempty: pfe_d    = avmm_writedata;
        AddrGearbox:     gb_d     = avmm_writedata;
        AddrCompCnt:     comp_d   = avmm_writedata;
        AddrMisc:        misc_d   = avmm_writedata;
        AddrClkLo:       clk_lo_d = avmm_writedata;
        AddrClkHi: begin
          clk_hi_d = avmm_writedata[ClkHiLsb +: 2];
          lock_d   = avmm_writedata[LockBit];
        end
        default: ;
      endcase
    end
  end

  // Read data mux; unmapped addresses read as zero.
  always_comb begin
    case (avmm_address)
      AddrCtrl:        rd_mux = ctrl_q;
      AddrFullEmpty:   rd_mux = fe_q;
      AddrPfullPempty: rd_mux = pfe_q;
      AddrGearbox:     rd_mux = gb_q;
      AddrCompCnt:     rd_mux = comp_q;
      AddrMisc:        rd_mux = misc_q;
      AddrClkLo:       rd_mux = clk_lo_q;
      AddrClkHi:       rd_mux = {lock_q, 5'b00000, clk_hi_q};
      AddrErrCnt:      rd_mux = err_cnt;
      default:         rd_mux = 8'h00;
    endcase
    readdata_d = do_rd ? rd_mux : readdata_q;
  end

  // Configuration and read-return registers.
  always_ff @(posedge avmm_clk) begin
    if (!avmm_rst_n) begin
      ctrl_q     <= 8'h00;
      fe_q       <= 8'h00;
      pfe_q      <= 8'h00;
      gb_q       <= 8'h00;
      comp_q     <= 8'h00;
      misc_q     <= 8'h00;
      clk_lo_q   <= 8'h00;
      clk_hi_q   <= 2'b00;
      lock_q     <= 1'b0;
      readdata_q <= 8'h00;
      rvalid_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      fe_q       <= fe_d;
      pfe_q      <= pfe_d;
      gb_q       <= gb_d;
      comp_q     <= comp_d;
      misc_q     <= misc_d;
      clk_lo_q   <= clk_lo_d;
      clk_hi_q   <= clk_hi_d;
      lock_q     <= lock_d;
      readdata_q <= readdata_d;
      rvalid_q   <= do_rd;
    end
  end

  c3aibadapt_cfg_errcnt u_errcnt (
    .clk_i  (avmm_clk),
    .rst_ni (avmm_rst_n),
    .inc_i  (err_inc),
    .cnt_o  (err_cnt),
    .err_o  (err_flag)
  );

  assign avmm_waitrequest   = (state_q == StIdle);
  assign avmm_readdata      = readdata_q;
  assign avmm_readdatavalid = rvalid_q;
  assign cfg_err            = err_flag;

  assign r_10g_mode         = ctrl_q[TenGModeBit];
  assign r_indv             = ctrl_q[IndvBit];
  assign r_fifo_mode        = ctrl_q[FifoModeLsb +: 3];
  assign r_double_read      = ctrl_q[DoubleReadBit];
  assign r_stop_read        = ctrl_q[StopReadBit];
  assign r_stop_write       = ctrl_q[StopWriteBit];
  assign r_full             = fe_q[FullLsb +: 4];
  assign r_empty            = fe_q[EmptyLsb +: 4];
  assign r_pfull            = pfe_q[PfullLsb +: 4];
  assign r_pempty           = pfe_q[PemptyLsb +: 4];
  assign r_gb_idwidth       = gb_q[GbIdwidthLsb +: 3];
  assign r_gb_odwidth       = gb_q[GbOdwidthLsb +: 2];
  assign r_phcomp_rd_delay  = gb_q[PhcompLsb +: 3];
  assign r_comp_cnt         = comp_q;
  assign r_full_type        = misc_q[FullTypeBit];
  assign r_empty_type       = misc_q[EmptyTypeBit];
  assign r_pfull_type       = misc_q[PfullTypeBit];
  assign r_pempty_type      = misc_q[PemptyTypeBit];
  assign r_compin_sel       = misc_q[CompinSelLsb +: 2];
  assign r_us_master        = misc_q[UsMasterBit];
  assign r_ds_master        = misc_q[DsMasterBit];
  assign tx_user_clk_config = {clk_hi_q, clk_lo_q};

endmodule

// File: tb/tb_c3aibadapt_tx_dprio_avmm.sv
// Self-checking bench for the TX adapter DPRIO register block; read results go through
// an expected-value queue filled when each read is issued.
module tb_c3aibadapt_tx_dprio_avmm;

  logic       avmm_clk = 1'b0;
  logic       avmm_rst_n = 1'b0;
  logic [5:0] avmm_address = '0;
  logic       avmm_write = 1'b0;
  logic       avmm_read = 1'b0;
  logic [7:0] avmm_writedata = '0;
  logic [7:0] avmm_readdata;
  logic       avmm_readdatavalid, avmm_waitrequest;
  logic       r_10g_mode, r_indv, r_double_read, r_stop_read, r_stop_write;
  logic [2:0] r_fifo_mode, r_gb_idwidth, r_phcomp_rd_delay;
  logic [3:0] r_full, r_empty, r_pfull, r_pempty;
  logic [1:0] r_gb_odwidth, r_compin_sel;
  logic [7:0] r_comp_cnt;
  logic       r_full_type, r_empty_type, r_pfull_type, r_pempty_type, r_us_master, r_ds_master;
  logic [9:0] tx_user_clk_config;
  logic       cfg_err;

  int         n_checks = 0;
  int         n_fails = 0;
  int         exp_err = 0;
  logic [7:0] exp_q[$];

  c3aibadapt_tx_dprio_avmm dut (
    .avmm_clk           (avmm_clk),
    .avmm_rst_n         (avmm_rst_n),
    .avmm_address       (avmm_address),
    .avmm_write         (avmm_write),
    .avmm_read          (avmm_read),
    .avmm_writedata     (avmm_writedata),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .avmm_waitrequest   (avmm_waitrequest),
    .r_10g_mode         (r_10g_mode),
    .r_indv             (r_indv),
    .r_fifo_mode        (r_fifo_mode),
    .r_double_read      (r_double_read),
    .r_stop_read        (r_stop_read),
    .r_stop_write       (r_stop_write),
    .r_full             (r_full),
    .r_empty            (r_empty),
    .r_pfull            (r_pfull),
    .r_pempty           (r_pempty),
    .r_gb_idwidth       (r_gb_idwidth),
    .r_gb_odwidth       (r_gb_odwidth),
    .r_phcomp_rd_delay  (r_phcomp_rd_delay),
    .r_comp_cnt         (r_comp_cnt),
    .r_full_type        (r_full_type),
    .r_empty_type       (r_empty_type),
    .r_pfull_type       (r_pfull_type),
    .r_pempty_type      (r_pempty_type),
    .r_compin_sel       (r_compin_sel),
    .r_us_master        (r_us_master),
    .r_ds_master        (r_ds_master),
    .tx_user_clk_config (tx_user_clk_config),
    .cfg_err            (cfg_err)
  );

  always #5 avmm_clk = ~avmm_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void note_err();
    if (exp_err < 255) exp_err++;
  endfunction

  // Full Avalon write: hold the request until accepted, then release after the ACK edge.
  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    int guard = 0;
    avmm_address = a; avmm_writedata = d; avmm_write = 1'b1; avmm_read = 1'b0;
    @(posedge avmm_clk); #1;
    while (avmm_waitrequest && guard < 8) begin @(posedge avmm_clk); #1; guard++; end
    n_checks++;
    if (guard >= 8) begin
      n_fails++;
      $display("FAIL write_accept addr=%h: waitrequest stayed 1, required 0 within 8 cycles", a);
    end
    @(posedge avmm_clk); #1;
    avmm_write = 1'b0;
  endtask

  // Full Avalon read; lat counts edges from request to readdatavalid, width its length.
  task automatic bus_read(input logic [5:0] a, output logic [7:0] d, output int lat,
                          output int width);
    int guard = 0;
    d = 'x; width = 0;
    avmm_address = a; avmm_read = 1'b1; avmm_write = 1'b0;
    @(posedge avmm_clk); #1; lat = 1;
    while (avmm_waitrequest && guard < 8) begin @(posedge avmm_clk); #1; lat++; guard++; end
    @(posedge avmm_clk); #1; lat++;
    avmm_read = 1'b0;
    if (avmm_readdatavalid) begin
      d = avmm_readdata; width = 1;
      @(posedge avmm_clk); #1;
      if (avmm_readdatavalid) width++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    int lat, w;
    avmm_rst_n = 1'b0;
    repeat (2) @(posedge avmm_clk);
    #1;
    n_checks++;
    if ({avmm_waitrequest, avmm_readdatavalid, avmm_readdata} !== 10'h200) begin
      n_fails++;
      $display("FAIL reset_bus: wr/rv/rd=%b/%b/%h, required 1/0/00",
               avmm_waitrequest, avmm_readdatavalid, avmm_readdata);
    end
    n_checks++;
    if ({r_10g_mode, r_indv, r_fifo_mode, r_double_read, r_stop_read, r_stop_write, r_full,
         r_empty, r_pfull, r_pempty, r_gb_idwidth, r_gb_odwidth, r_phcomp_rd_delay, r_comp_cnt,
         r_full_type, r_empty_type, r_pfull_type, r_pempty_type, r_compin_sel, r_us_master,
         r_ds_master, tx_user_clk_config, cfg_err} !== '0) begin
      n_fails++;
      $display("FAIL reset_cfg: comp_cnt=%h clk_cfg=%h cfg_err=%b, required all zero",
               r_comp_cnt, tx_user_clk_config, cfg_err);
    end
    avmm_rst_n = 1'b1;
    @(posedge avmm_clk); #1;
    for (int i = 7; i <= 8; i++) begin
      exp_q.push_back(8'h00);
      bus_read(6'(i), d, lat, w);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e || w != 1) begin
        n_fails++;
        $display("FAIL reset_read addr=%0d: got %h width %0d, required %h width 1", i, d, w, e);
      end
    end
  endtask

  task automatic test_regmap();
    logic [5:0] addrs[6] = '{6'h04, 6'h01, 6'h02, 6'h03, 6'h05, 6'h06};
    logic [7:0] vals[6]  = '{8'hA5, 8'h3C, 8'h96, 8'hB3, 8'h6A, 8'h5B};
    logic [7:0] d, e;
    int lat, w;
    bus_write(6'h04, 8'hA5);
    n_checks++;
    if (r_comp_cnt !== 8'hA5) begin
      n_fails++; $display("FAIL comp_cnt_write: got %h, required a5", r_comp_cnt);
    end
    exp_q.push_back(8'hA5);
    bus_read(6'h04, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e || lat != 2 || w != 1) begin
      n_fails++;
      $display("FAIL comp_cnt_read: got %h lat %0d width %0d, required %h lat 2 width 1",
               d, lat, w, e);
    end
    for (int i = 1; i < 6; i++) bus_write(addrs[i], vals[i]);
    n_checks++;
    if ({r_empty, r_full, r_pempty, r_pfull} !== 16'h3C96) begin
      n_fails++;
      $display("FAIL fifo_thresh: e/f/pe/pf=%h/%h/%h/%h, required 3/c/9/6",
               r_empty, r_full, r_pempty, r_pfull);
    end
    n_checks++;
    if (r_gb_idwidth !== 3'b011 || r_gb_odwidth !== 2'b10 || r_phcomp_rd_delay !== 3'b101) begin
      n_fails++;
      $display("FAIL gearbox: id/od/ph=%b/%b/%b, required 011/10/101",
               r_gb_idwidth, r_gb_odwidth, r_phcomp_rd_delay);
    end
    n_checks++;
    if (r_full_type !== 1'b0 || r_empty_type !== 1'b1 || r_pfull_type !== 1'b0 ||
        r_pempty_type !== 1'b1 || r_compin_sel !== 2'b10 || r_us_master !== 1'b1 ||
        r_ds_master !== 1'b0) begin
      n_fails++;
      $display("FAIL misc: ft/et/pft/pet/cs/us/ds=%b/%b/%b/%b/%b/%b/%b, required 0/1/0/1/10/1/0",
               r_full_type, r_empty_type, r_pfull_type, r_pempty_type, r_compin_sel,
               r_us_master, r_ds_master);
    end
    n_checks++;
    if (tx_user_clk_config !== 10'h05B || cfg_err !== 1'b0) begin
      n_fails++;
      $display("FAIL clk_lo: clk_cfg=%h cfg_err=%b, required 05b 0", tx_user_clk_config, cfg_err);
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vals[i]);
      bus_read(addrs[i], d, lat, w);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e || w != 1) begin
        n_fails++;
        $display("FAIL readback addr=%h: got %h width %0d, required %h width 1", addrs[i], d, w, e);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] d, e;
    int lat, w;
    bus_write(6'h07, 8'h83);
    n_checks++;
    if (tx_user_clk_config[9:8] !== 2'b11 || cfg_err !== 1'b0) begin
      n_fails++;
      $display("FAIL lock_set: clk_hi=%b cfg_err=%b, required 11 0", tx_user_clk_config[9:8],
               cfg_err);
    end
    bus_write(6'h00, 8'hFF); note_err();
    n_checks++;
    if (r_10g_mode !== 1'b0 || r_stop_write !== 1'b0 || cfg_err !== 1'b1) begin
      n_fails++;
      $display("FAIL locked_write: 10g=%b stop_wr=%b cfg_err=%b, required 0 0 1",
               r_10g_mode, r_stop_write, cfg_err);
    end
    bus_write(6'h04, 8'h00); note_err();
    n_checks++;
    if (r_comp_cnt !== 8'hA5) begin
      n_fails++; $display("FAIL locked_comp_cnt: got %h, required a5", r_comp_cnt);
    end
    exp_q.push_back(8'(exp_err));
    exp_q.push_back(8'h83);
    bus_read(6'h08, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("FAIL lock_err_cnt: got %h, required %h", d, e); end
    bus_read(6'h07, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("FAIL lock_readback: got %h, required %h", d, e); end
  endtask

  task automatic test_unlock();
    logic [7:0] d, e;
    int lat, w;
    bus_write(6'h07, 8'h00);
    bus_write(6'h00, 8'h1D);
    n_checks++;
    if (r_fifo_mode !== 3'b111 || r_10g_mode !== 1'b1 || r_indv !== 1'b0 ||
        r_double_read !== 1'b0) begin
      n_fails++;
      $display("FAIL unlock_ctrl: fifo/10g/indv/dr=%b/%b/%b/%b, required 111/1/0/0",
               r_fifo_mode, r_10g_mode, r_indv, r_double_read);
    end
    bus_write(6'h07, 8'h7E);
    n_checks++;
    if (tx_user_clk_config !== 10'h25B) begin
      n_fails++; $display("FAIL clk_hi: got %h, required 25b", tx_user_clk_config);
    end
    exp_q.push_back(8'h02);
    bus_read(6'h07, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("FAIL reg07_zero_bits: got %h, required %h", d, e); end
  endtask

  task automatic test_illegal();
    logic [5:0] ra[3] = '{6'h20, 6'h3F, 6'h09};
    logic [7:0] d, e;
    int lat, w;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      bus_read(ra[i], d, lat, w);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e || w != 1) begin
        n_fails++;
        $display("FAIL unmapped_read addr=%h: got %h width %0d, required %h width 1", ra[i], d, w, e);
      end
    end
    bus_write(6'h20, 8'hFF); note_err();
    exp_q.push_back(8'(exp_err));
    bus_read(6'h08, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("FAIL unmapped_write_err: got %h, required %h", d, e); end
    bus_write(6'h08, 8'h00); note_err();
    exp_q.push_back(8'(exp_err));
    bus_read(6'h08, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e || cfg_err !== 1'b1) begin
      n_fails++;
      $display("FAIL errcnt_write: got %h cfg_err %b, required %h 1", d, cfg_err, e);
    end
  endtask

  // Request strobes that drop before ACK still complete with ACK-cycle address/data.
  task automatic test_drop();
    logic [7:0] e;
    avmm_address = 6'h3F; avmm_writedata = 8'hEE; avmm_write = 1'b1;
    @(posedge avmm_clk); #1;
    avmm_write = 1'b0; avmm_address = 6'h04; avmm_writedata = 8'h33;
    @(posedge avmm_clk); #1;
    n_checks++;
    if (r_comp_cnt !== 8'h33) begin
      n_fails++; $display("FAIL dropped_write: comp_cnt=%h, required 33", r_comp_cnt);
    end
    avmm_address = 6'h3F; avmm_read = 1'b1;
    exp_q.push_back(8'h33);
    @(posedge avmm_clk); #1;
    avmm_read = 1'b0; avmm_address = 6'h04;
    @(posedge avmm_clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (avmm_readdatavalid !== 1'b1 || avmm_readdata !== e) begin
      n_fails++;
      $display("FAIL dropped_read: valid %b data %h, required 1 %h", avmm_readdatavalid,
               avmm_readdata, e);
    end
    @(posedge avmm_clk); #1;
  endtask

  task automatic test_both();
    logic [7:0] d, e;
    int lat, w, seen = 0;
    avmm_address = 6'h03; avmm_writedata = 8'h2A; avmm_read = 1'b1; avmm_write = 1'b1;
    @(posedge avmm_clk); #1;
    @(posedge avmm_clk); #1;
    avmm_read = 1'b0; avmm_write = 1'b0;
    seen += int'(avmm_readdatavalid);
    @(posedge avmm_clk); #1;
    seen += int'(avmm_readdatavalid);
    note_err();
    n_checks++;
    if (seen != 0 || r_gb_idwidth !== 3'b010 || r_gb_odwidth !== 2'b01 ||
        r_phcomp_rd_delay !== 3'b001 || cfg_err !== 1'b1) begin
      n_fails++;
      $display("FAIL rd_wr_both: rv_cycles=%0d id/od/ph=%b/%b/%b err=%b, required 0 010/01/001 1",
               seen, r_gb_idwidth, r_gb_odwidth, r_phcomp_rd_delay, cfg_err);
    end
    exp_q.push_back(8'(exp_err));
    bus_read(6'h08, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("FAIL rd_wr_both_err: got %h, required %h", d, e); end
  endtask

  task automatic test_saturate();
    logic [7:0] d, e;
    int lat, w;
    for (int i = 0; i < 260; i++) begin
      bus_write(6'h30, 8'(i)); note_err();
    end
    exp_q.push_back(8'(exp_err));
    bus_read(6'h08, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e || e !== 8'hFF) begin
      n_fails++; $display("FAIL err_saturate: got %h, required %h (ff)", d, e);
    end
  endtask

  task automatic test_rst_in_ack();
    logic [7:0] d, e;
    int lat, w;
    avmm_address = 6'h01; avmm_writedata = 8'hFF; avmm_write = 1'b1;
    @(posedge avmm_clk); #1;
    avmm_rst_n = 1'b0;
    @(posedge avmm_clk); #1;
    avmm_write = 1'b0;
    exp_err = 0;
    n_checks++;
    if (r_full !== 4'h0 || r_empty !== 4'h0 || avmm_readdatavalid !== 1'b0 ||
        avmm_waitrequest !== 1'b1 || cfg_err !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_ack_write: full/empty=%h/%h rv=%b wr=%b err=%b, required 0/0 0 1 0",
               r_full, r_empty, avmm_readdatavalid, avmm_waitrequest, cfg_err);
    end
    avmm_rst_n = 1'b1;
    @(posedge avmm_clk); #1;
    n_checks++;
    if (r_full !== 4'h0 || avmm_readdatavalid !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_ack_after: full=%h rv=%b, required 0 0", r_full, avmm_readdatavalid);
    end
    bus_write(6'h04, 8'h77);
    avmm_address = 6'h04; avmm_read = 1'b1;
    @(posedge avmm_clk); #1;
    avmm_rst_n = 1'b0;
    @(posedge avmm_clk); #1;
    avmm_read = 1'b0;
    avmm_rst_n = 1'b1;
    @(posedge avmm_clk); #1;
    n_checks++;
    if (avmm_readdatavalid !== 1'b0 || avmm_readdata !== 8'h00 || r_comp_cnt !== 8'h00) begin
      n_fails++;
      $display("FAIL rst_ack_read: rv=%b rd=%h comp=%h, required 0 00 00",
               avmm_readdatavalid, avmm_readdata, r_comp_cnt);
    end
    exp_q.push_back(8'(exp_err));
    bus_read(6'h08, d, lat, w);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("FAIL rst_err_clear: got %h, required %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_lock();
    test_unlock();
    test_illegal();
    test_drop();
    test_both();
    test_saturate();
    test_rst_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/c3aibadapt_tx_dprio_avmm.md
C3AIBADAPT_TX_DPRIO_AVMM -- requirements
Module: c3aibadapt_tx_dprio_avmm

Interface
REQ-001 SHALL have one clock and one reset: synchronous, active-low.
- avmm_clk  in  1  sole clock; all state updates on its rising edge.
- avmm_rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL provide these Avalon-MM responder ports:
- avmm_address  in  6  byte register address.
- avmm_write  in  1  write request.
- avmm_read  in  1  read request.
- avmm_writedata  in  8  write data.
- avmm_readdata  out  8  read data.
- avmm_readdatavalid  out  1  one-cycle read-data strobe.
- avmm_waitrequest  out  1  stall; request is accepted in the cycle this is low.
REQ-003 SHALL provide these config outputs, each a direct register field:
- r_10g_mode, r_indv, r_fifo_mode[2:0], r_double_read, r_stop_read, r_stop_write
- r_full[3:0], r_empty[3:0], r_pfull[3:0], r_pempty[3:0]
- r_gb_idwidth[2:0], r_gb_odwidth[1:0], r_phcomp_rd_delay[2:0], r_comp_cnt[7:0]
- r_full_type, r_empty_type, r_pfull_type, r_pempty_type, r_compin_sel[1:0], r_us_master, r_ds_master
- tx_user_clk_config[9:0]
- cfg_err  out  1  sticky error flag.

Function
REQ-004 SHALL use this register map (bit positions MSB:LSB):
- 0x00: stop_write[7], stop_read[6], double_read[5], fifo_mode[4:2], indv[1], 10g_mode[0].
- 0x01: empty[7:4], full[3:0].
- 0x02: pempty[7:4], pfull[3:0].
- 0x03: phcomp_rd_delay[7:5], gb_odwidth[4:3], gb_idwidth[2:0].
- 0x04: comp_cnt[7:0].
- 0x05: ds_master[7], us_master[6], compin_sel[5:4], pempty_type[3], pfull_type[2], empty_type[1], full_type[0].
- 0x06: tx_user_clk_config[7:0].
- 0x07: lock[7], tx_user_clk_config[9:8] at [1:0], bits [6:2] read 0.
- 0x08 (RO): err_cnt[7:0].
REQ-005 SHALL implement a two-state FSM: IDLE and ACK.
REQ-006 SHALL drive avmm_waitrequest=1 in IDLE and avmm_waitrequest=0 in ACK.
REQ-007 IDLE->ACK SHALL occur when avmm_read or avmm_write is 1.
REQ-008 ACK->IDLE SHALL occur unconditionally, so each access costs exactly 2 cycles.
REQ-009 Write commit: in ACK, address and data are sampled; the register SHALL update at the end of the ACK cycle.
REQ-010 Read: in ACK, avmm_readdata SHALL be registered; avmm_readdatavalid=1 for exactly the following cycle.
REQ-011 avmm_readdata SHALL hold its last value outside valid cycles.
REQ-012 Reads of addresses 0x09-0x3F SHALL return 0x00.
REQ-013 Writes to 0x08 or to 0x09-0x3F SHALL be ignored; cfg_err SHALL be set and err_cnt SHALL increment.
REQ-014 While lock=1, writes to 0x00-0x06 SHALL be ignored, set cfg_err and increment err_cnt.
REQ-015 Register 0x07 SHALL remain writable while lock=1, so clearing lock is possible.
REQ-016 read=write=1 in ACK SHALL be executed as a write only: no readdatavalid, cfg_err set, err_cnt incremented.
REQ-017 err_cnt SHALL saturate at 0xFF.
REQ-018 Writing any value to 0x08 SHALL NOT clear err_cnt; err_cnt and cfg_err clear only on reset.
REQ-019 Request inputs that drop before ACK SHALL still complete, using the values sampled in ACK.

Reset
REQ-020 With avmm_rst_n=0 at a clock edge, FSM=IDLE, waitrequest=1, readdatavalid=0, readdata=0x00.
REQ-021 Reset values: all config registers 0, lock=0, err_cnt=0, cfg_err=0; exceptions r_comp_cnt=0x00 and tx_user_clk_config=10'h000.
REQ-022 Reset asserted during ACK SHALL abort the access: no register update and no readdatavalid.

Structure
REQ-023 A shared package SHALL hold the register address constants, the FSM state enum and field bit-position constants.
REQ-024 A single sub-module, c3aibadapt_cfg_errcnt (saturating counter plus sticky flag), SHALL be instantiated; everything else is flat.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Write 0x04=0xA5 -> r_comp_cnt=0xA5 after the ACK cycle; read 0x04 -> readdata=0xA5, readdatavalid=1 for one cycle, 2 cycles after the request.
- Write 0x07=0x83, then write 0x00=0xFF -> tx_user_clk_config[9:8]=2'b11; r_10g_mode stays 0; cfg_err=1; err_cnt=1.
- Write 0x07=0x00, then write 0x00=0x1D -> lock cleared; r_fifo_mode=3'b111, r_10g_mode=1, r_indv=0.
- Read 0x20 -> 0x00; write 0x20 -> err_cnt increments.
- 260 illegal writes -> err_cnt=0xFF, no wrap.
- avmm_rst_n=0 during ACK of write 0x01=0xFF -> r_full=0, r_empty=0, readdatavalid=0.
- read=write=1 at 0x03 with data 0x2A -> r_gb_idwidth=3'b010, r_gb_odwidth=2'b01, r_phcomp_rd_delay=3'b001, no readdatavalid, cfg_err=1.
